booth_mult_seq: RTL

Parametrised sequential radix-4 Booth multiplier, successor to the fixed 32-bit multiplier in the ALU datapath. Adds generic operand width, a signed/unsigned mode, a start/busy/done handshake, and a real reset. It retires one Booth digit (2 multiplier bits) per clock and feeds the MUL path that writes HI/LO.

---
 rtl/booth_mult_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock,
// with a start/ready/busy/done handshake and a signed/unsigned mode.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * EW;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_acc;
  logic [EW-1:0]      r_a;
  logic               r_bprev;
  logic [2*WIDTH-1:0] r_product;

  logic [2:0]    w_trip;
  logic [EW-1:0] w_a2;
  logic [EW-1:0] w_term;
  logic [EW-1:0] w_sum;
  logic [AW-1:0] w_acc_next;
  logic [EW-1:0] w_a_ext;
  logic [EW-1:0] w_b_ext;

  // Two extension bits let unsigned operands run through the signed Booth path exactly.
  assign w_a_ext = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_b_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
  assign w_a2    = {r_a[EW-2:0], 1'b0};

  always_comb begin
    w_trip = {r_acc[1:0], r_bprev};
    case (w_trip)
      3'b001, 3'b010: w_term = r_a;
      3'b011:         w_term = w_a2;
      3'b100:         w_term = -w_a2;
      3'b101, 3'b110: w_term = -r_a;
      default:        w_term = '0;
    endcase
    w_sum      = r_acc[AW-1:EW] + w_term;
    w_acc_next = $signed({w_sum, r_acc[EW-1:0]}) >>> 2;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_bprev   <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= w_a_ext;
            r_acc   <= {{EW{1'b0}}, w_b_ext};
            r_bprev <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          // N digit steps, then one more cycle to publish the product.
          if (r_cnt == CW'(N)) begin
            r_product <= r_acc[2*WIDTH-1:0];
            r_state   <= S_DONE;
          end else begin
            r_acc   <= w_acc_next;
            r_bprev <= r_acc[1];
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy    = (r_state == S_CALC);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
